// File: rtl/mac_job_sequencer_if.sv
// Host-side channels of the MAC job sequencer: command in, operand beats in, result out.
// The master drives commands/operands and consumes results; the slave is the sequencer.
interface mac_job_sequencer_if #(
    parameter int MAC_CONF_WIDTH = 4,
    parameter int MAC_MIN_WIDTH  = 8,
    parameter int MAC_ACC_WIDTH  = 32,
    parameter int LEN_WIDTH      = 16
);
    logic                         cmd_valid;
    logic                         cmd_ready;
    logic [MAC_CONF_WIDTH-1:0]    cmd_cfg;
    logic [4*MAC_ACC_WIDTH-1:0]   cmd_init;
    logic [LEN_WIDTH-1:0]         cmd_len;

    logic                         op_valid;
    logic                         op_ready;
    logic [4*MAC_MIN_WIDTH-1:0]   op_a;
    logic [4*MAC_MIN_WIDTH-1:0]   op_b;

    logic                         res_valid;
    logic                         res_ready;
    logic [4*MAC_ACC_WIDTH-1:0]   res_data;

    logic                         busy;

    modport master (
        output cmd_valid, cmd_cfg, cmd_init, cmd_len,
        output op_valid, op_a, op_b,
        output res_ready,
        input  cmd_ready, op_ready, res_valid, res_data, busy
    );

    modport slave (
        input  cmd_valid, cmd_cfg, cmd_init, cmd_len,
        input  op_valid, op_a, op_b,
        input  res_ready,
        output cmd_ready, op_ready, res_valid, res_data, busy
    );
endinterface

// File: rtl/mac_job_sequencer.sv
// Runs one complete MAC job at a time on an attached mac_cluster: configure, stream
// operand beats, drain the cluster pipeline, capture and return the accumulator.
module mac_job_sequencer #(
    parameter int MAC_CONF_WIDTH = 4,
    parameter int MAC_MIN_WIDTH  = 8,
    parameter int MAC_ACC_WIDTH  = 32,
    parameter int MAC_LATENCY    = 2,
    parameter int LEN_WIDTH      = 16
) (
    input  logic                                  clk,
    input  logic                                  reset,
    mac_job_sequencer_if.slave                    bus,
    output logic                                  mac_cset,
    output logic                                  mac_en,
    output logic [4*MAC_ACC_WIDTH+MAC_CONF_WIDTH-1:0] mac_cfg,
    output logic [4*MAC_MIN_WIDTH-1:0]            mac_a,
    output logic [4*MAC_MIN_WIDTH-1:0]            mac_b,
    input  logic [4*MAC_ACC_WIDTH-1:0]            mac_out
);
    localparam int OP_W    = 4 * MAC_MIN_WIDTH;
    localparam int RES_W   = 4 * MAC_ACC_WIDTH;
    localparam int CFG_W   = RES_W + MAC_CONF_WIDTH;
    localparam int DRAIN_W = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONFIG,
        S_STREAM,
        S_DRAIN,
        S_CAPTURE,
        S_RESULT
    } state_t;

    state_t               state_reg, state_next;
    logic                 mac_cset_reg, mac_cset_next;
    logic                 mac_en_reg, mac_en_next;
    logic [CFG_W-1:0]     mac_cfg_reg, mac_cfg_next;
    logic [OP_W-1:0]      mac_a_reg, mac_a_next;
    logic [OP_W-1:0]      mac_b_reg, mac_b_next;
    logic                 res_valid_reg, res_valid_next;
    logic [RES_W-1:0]     res_data_reg, res_data_next;
    logic                 busy_reg, busy_next;
    logic [LEN_WIDTH-1:0] remaining_reg, remaining_next;
    logic [DRAIN_W-1:0]   drain_reg, drain_next;

    logic beat_accept;

    assign bus.cmd_ready = (state_reg == S_IDLE);
    assign bus.op_ready  = (state_reg == S_STREAM) && (remaining_reg != '0);
    assign beat_accept   = bus.op_valid && bus.op_ready;

    assign mac_cset      = mac_cset_reg;
    assign mac_en        = mac_en_reg;
    assign mac_cfg       = mac_cfg_reg;
    assign mac_a         = mac_a_reg;
    assign mac_b         = mac_b_reg;
    assign bus.res_valid = res_valid_reg;
    assign bus.res_data  = res_data_reg;
    assign bus.busy      = busy_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            mac_cset_reg  <= 1'b0;
            mac_en_reg    <= 1'b0;
            mac_cfg_reg   <= '0;
            mac_a_reg     <= '0;
            mac_b_reg     <= '0;
            res_valid_reg <= 1'b0;
            res_data_reg  <= '0;
            busy_reg      <= 1'b0;
            remaining_reg <= '0;
            drain_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            mac_cset_reg  <= mac_cset_next;
            mac_en_reg    <= mac_en_next;
            mac_cfg_reg   <= mac_cfg_next;
            mac_a_reg     <= mac_a_next;
            mac_b_reg     <= mac_b_next;
            res_valid_reg <= res_valid_next;
            res_data_reg  <= res_data_next;
            busy_reg      <= busy_next;
            remaining_reg <= remaining_next;
            drain_reg     <= drain_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        mac_cset_next  = 1'b0;
        mac_en_next    = 1'b0;
        mac_cfg_next   = mac_cfg_reg;
        mac_a_next     = mac_a_reg;
        mac_b_next     = mac_b_reg;
        res_valid_next = res_valid_reg;
        res_data_next  = res_data_reg;
        remaining_next = remaining_reg;
        drain_next     = drain_reg;

        case (state_reg)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    mac_cfg_next   = {bus.cmd_init, bus.cmd_cfg};
                    remaining_next = bus.cmd_len;
                    mac_cset_next  = 1'b1;
                    state_next     = S_CONFIG;
                end
            end
            S_CONFIG: begin
                state_next = (remaining_reg == '0) ? S_CAPTURE : S_STREAM;
            end
            S_STREAM: begin
                // A bubble leaves mac_en low so the cluster freezes with operands held.
                if (beat_accept) begin
                    mac_a_next     = bus.op_a;
                    mac_b_next     = bus.op_b;
                    mac_en_next    = 1'b1;
                    remaining_next = remaining_reg - LEN_WIDTH'(1);
                    if (remaining_reg == LEN_WIDTH'(1)) begin
                        state_next = S_DRAIN;
                        drain_next = DRAIN_W'(MAC_LATENCY - 1);
                    end
                end
            end
            S_DRAIN: begin
                // Zero operands push the last real product through the pipeline.
                if (drain_reg != '0) begin
                    mac_en_next = 1'b1;
                    mac_a_next  = '0;
                    mac_b_next  = '0;
                    drain_next  = drain_reg - DRAIN_W'(1);
                end else begin
                    state_next = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                res_data_next  = mac_out;
                res_valid_next = 1'b1;
                state_next     = S_RESULT;
            end
            S_RESULT: begin
                if (bus.res_ready) begin
                    res_valid_next = 1'b0;
                    state_next     = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        busy_next = (state_next != S_IDLE);
    end
endmodule

// File: tb/tb_mac_job_sequencer.sv
// Directed bench for mac_job_sequencer with a small behavioural mac_cluster attached.
// Each job's result and timing are compared against hand-computed values.
module tb_mac_job_sequencer;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         mac_cset;
    logic         mac_en;
    logic [131:0] mac_cfg;
    logic [31:0]  mac_a;
    logic [31:0]  mac_b;
    logic [127:0] mac_out;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int en_cnt = 0;
    int last_en_cyc = 0;
    int en_base;
    int cset_cyc;
    int last_acc_cyc;
    int rv_cyc;
    logic [131:0] cur_cfg;
    logic [31:0]  beat_a [8];
    logic [31:0]  beat_b [8];

    mac_job_sequencer_if bus ();

    mac_job_sequencer dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .mac_cset (mac_cset),
        .mac_en   (mac_en),
        .mac_cfg  (mac_cfg),
        .mac_a    (mac_a),
        .mac_b    (mac_b),
        .mac_out  (mac_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mac_en) begin
            en_cnt      <= en_cnt + 1;
            last_en_cyc <= cyc;
        end
    end

    // Behavioural cluster: product stage then accumulator stage, both gated by mac_en.
    function automatic logic [127:0] mac_prod(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [127:0] r, ea, eb, t;
        r = '0;
        case (c[1:0])
            2'd0: for (int l = 0; l < 4; l++) begin
                ea = c[3] ? {{120{a[8*l+7]}}, a[8*l +: 8]} : {120'b0, a[8*l +: 8]};
                eb = c[3] ? {{120{b[8*l+7]}}, b[8*l +: 8]} : {120'b0, b[8*l +: 8]};
                t = ea * eb;
                r[32*l +: 32] = t[31:0];
            end
            2'd1: for (int l = 0; l < 2; l++) begin
                ea = c[3] ? {{112{a[16*l+15]}}, a[16*l +: 16]} : {112'b0, a[16*l +: 16]};
                eb = c[3] ? {{112{b[16*l+15]}}, b[16*l +: 16]} : {112'b0, b[16*l +: 16]};
                t = ea * eb;
                r[64*l +: 64] = t[63:0];
            end
            default: begin
                ea = c[3] ? {{96{a[31]}}, a} : {96'b0, a};
                eb = c[3] ? {{96{b[31]}}, b} : {96'b0, b};
                r = ea * eb;
            end
        endcase
        return r;
    endfunction

    function automatic logic [127:0] mac_add(input logic [3:0] c, input logic [127:0] x, input logic [127:0] y);
        logic [127:0] r;
        r = '0;
        case (c[1:0])
            2'd0: for (int l = 0; l < 4; l++) r[32*l +: 32] = x[32*l +: 32] + y[32*l +: 32];
            2'd1: for (int l = 0; l < 2; l++) r[64*l +: 64] = x[64*l +: 64] + y[64*l +: 64];
            default: r = x + y;
        endcase
        return r;
    endfunction

    logic [127:0] cl_acc = '0;
    logic [127:0] cl_p = '0;

    always @(posedge clk) begin
        if (mac_cset) begin
            cl_acc <= mac_cfg[131:4];
            cl_p   <= '0;
        end else if (mac_en) begin
            cl_p   <= mac_prod(mac_cfg[3:0], mac_a, mac_b);
            cl_acc <= mac_cfg[2] ? mac_add(mac_cfg[3:0], cl_acc, cl_p) : cl_p;
        end
    end
    assign mac_out = cl_acc;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic issue_cmd(input logic [3:0] cfg, input logic [127:0] init, input int len);
        check("cmd_ready_idle", bus.cmd_ready, 1'b1);
        check("op_ready_idle", bus.op_ready, 1'b0);
        bus.cmd_valid = 1'b1;
        bus.cmd_cfg   = cfg;
        bus.cmd_init  = init;
        bus.cmd_len   = 16'(len);
        cur_cfg       = {init, cfg};
        en_base       = en_cnt;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        cset_cyc      = cyc;
        check("config_cset", mac_cset, 1'b1);
        check("config_en", mac_en, 1'b0);
        check("config_cfg", mac_cfg, cur_cfg);
        check("config_busy", bus.busy, 1'b1);
        check("config_cmd_ready", bus.cmd_ready, 1'b0);
        check("config_op_ready", bus.op_ready, 1'b0);
    endtask

    task automatic stream_beats(input int n, input bit stall);
        int  i = 0;
        int  guard = 0;
        bit  prev_acc = 1'b0;
        while (i < n && guard < 100) begin
            @(negedge clk);
            guard++;
            check("en_follows_accept", mac_en, prev_acc);
            bus.op_valid = !(stall && (guard % 2 == 0));
            bus.op_a     = beat_a[i];
            bus.op_b     = beat_b[i];
            prev_acc     = bus.op_valid && bus.op_ready;
            if (prev_acc) begin
                i++;
                last_acc_cyc = cyc;
            end
        end
        if (i < n) check("beat_timeout", 128'(i), 128'(n));
    endtask

    task automatic finish_job(input string tag, input int len, input int hold, input logic [127:0] exp);
        int g = 0;
        if (len > 0) begin
            @(negedge clk);
            check("last_beat_en", mac_en, 1'b1);
            check("last_beat_a", mac_a, beat_a[len-1]);
            check("op_ready_exhausted", bus.op_ready, 1'b0);
            bus.op_valid = 1'b0;
            @(negedge clk);
            check("drain_en", mac_en, 1'b1);
            check("drain_a", mac_a, 32'd0);
        end
        @(negedge clk);
        while (!bus.res_valid && g < 20) begin
            @(negedge clk);
            g++;
        end
        check("res_valid_timeout", bus.res_valid, 1'b1);
        rv_cyc = cyc;
        if (len > 0) begin
            check("lat_from_accept", 128'(rv_cyc - last_acc_cyc), 128'd4);
            check("lat_from_last_en", 128'(rv_cyc - last_en_cyc), 128'd2);
        end else begin
            check("lat_from_cset", 128'(rv_cyc - cset_cyc), 128'd2);
        end
        check("en_count", 128'(en_cnt - en_base), 128'(len + ((len > 0) ? 1 : 0)));
        check("cfg_held", mac_cfg, cur_cfg);
        for (int h = 0; h < hold; h++) begin
            check("res_hold_valid", bus.res_valid, 1'b1);
            check("res_hold_data", bus.res_data, exp);
            @(negedge clk);
        end
        check("res_data", bus.res_data, exp);
        $display("job %s: res_data %h expected %h", tag, bus.res_data, exp);
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        check("res_valid_drop", bus.res_valid, 1'b0);
        check("busy_drop", bus.busy, 1'b0);
        check("cmd_ready_back", bus.cmd_ready, 1'b1);
    endtask

    task automatic run_job(input string tag, input logic [3:0] cfg, input logic [127:0] init, input int len,
                           input bit stall, input int hold, input logic [127:0] exp);
        issue_cmd(cfg, init, len);
        stream_beats(len, stall);
        finish_job(tag, len, hold, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_cfg   = '0;
        bus.cmd_init  = '0;
        bus.cmd_len   = '0;
        bus.op_valid  = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.res_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cset", mac_cset, 1'b0);
        check("rst_en", mac_en, 1'b0);
        check("rst_cfg", mac_cfg, 132'd0);
        check("rst_a", mac_a, 32'd0);
        check("rst_b", mac_b, 32'd0);
        check("rst_res_valid", bus.res_valid, 1'b0);
        check("rst_res_data", bus.res_data, 128'd0);
        check("rst_busy", bus.busy, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        // SINGLE unsigned accumulate: 3 beats of 2*2 per lane
        for (int i = 0; i < 3; i++) begin
            beat_a[i] = 32'h02020202;
            beat_b[i] = 32'h02020202;
        end
        run_job("single_acc", 4'b0100, 128'd0, 3, 1'b0, 0, {4{32'd12}});

        // SINGLE signed non-accumulate: only (-4)*(-4) survives in lane 0
        beat_a[0] = 32'h000000FD; beat_b[0] = 32'h00000005;
        beat_a[1] = 32'h000000FC; beat_b[1] = 32'h000000FC;
        run_job("single_signed", 4'b1000, {4{32'd7}}, 2, 1'b0, 0, 128'd16);

        // Zero-length job returns the init values untouched
        run_job("len_zero", 4'b0100, {32'd4, 32'd3, 32'd2, 32'd1}, 0, 1'b0, 0,
                {32'd4, 32'd3, 32'd2, 32'd1});

        // Stalled operand stream and a held-off result consumer
        for (int i = 0; i < 3; i++) begin
            beat_a[i] = 32'h02020202;
            beat_b[i] = 32'h02020202;
        end
        run_job("single_stall", 4'b0100, 128'd0, 3, 1'b1, 5, {4{32'd12}});

        // Reset after 2 of 4 beats: abort without a result
        for (int i = 0; i < 4; i++) begin
            beat_a[i] = 32'h01010101;
            beat_b[i] = 32'h01010101;
        end
        issue_cmd(4'b0100, 128'd0, 4);
        stream_beats(2, 1'b0);
        @(negedge clk);
        bus.op_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", bus.busy, 1'b0);
        check("abort_en", mac_en, 1'b0);
        check("abort_cset", mac_cset, 1'b0);
        check("abort_res_valid", bus.res_valid, 1'b0);
        check("abort_cmd_ready", bus.cmd_ready, 1'b1);
        check("abort_op_ready", bus.op_ready, 1'b0);
        repeat (4) begin
            @(negedge clk);
            check("abort_no_result", bus.res_valid, 1'b0);
        end
        $display("job abort: reset mid-stream, sequencer idle");

        // QUAD unsigned accumulate after the abort
        beat_a[0] = 32'd65536;
        beat_b[0] = 32'd3;
        run_job("quad_acc", 4'b0110, 128'd100, 1, 1'b0, 0, 128'd196708);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mac_job_sequencer.md
Name: mac_job_sequencer

Overview:
- Command-driven controller that owns one mac_cluster instance and runs complete MAC jobs on it.
- Per job: accepts a command (mode cfg, four initial accumulators, beat count), loads the cluster via cset, streams operand beats under valid/ready, drains the cluster pipeline, and returns the final four-lane accumulator as one result beat.
- Sits between the fabric/host request logic and the mac_cluster datapath.

Parameters:
- MAC_CONF_WIDTH, 4, cluster config width: [1:0] mode (MAC_SINGLE/DUAL/QUAD), [2] accumulate, [3] signed.
- MAC_MIN_WIDTH, 8, per-lane operand width.
- MAC_ACC_WIDTH, 32, per-lane accumulator width.
- MAC_LATENCY, 2, cluster latency: mac_en=1 cycles from operands applied to mac_out valid.
- LEN_WIDTH, 16, beat-count width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command valid
- cmd_ready  out  1  high only in IDLE
- cmd_cfg  in  MAC_CONF_WIDTH  job mode
- cmd_init  in  4*MAC_ACC_WIDTH  {init3,init2,init1,init0}
- cmd_len  in  LEN_WIDTH  operand beats in job (0 allowed)
- op_valid  in  1  operand beat valid
- op_ready  out  1  operand beat accepted when op_valid&op_ready
- op_a, op_b  in  4*MAC_MIN_WIDTH  {A3,A2,A1,A0} / {B3,B2,B1,B0}
- res_valid  out  1  result valid
- res_ready  in  1  result consumer ready
- res_data  out  4*MAC_ACC_WIDTH  {out3,out2,out1,out0}
- busy  out  1  state != IDLE
- mac_cset  out  1  cluster config strobe
- mac_en  out  1  cluster enable; 0 freezes all cluster registers
- mac_cfg  out  4*MAC_ACC_WIDTH+MAC_CONF_WIDTH  {init3..init0, cfg}
- mac_a, mac_b  out  4*MAC_MIN_WIDTH  cluster operands
- mac_out  in  4*MAC_ACC_WIDTH  cluster outputs {out3..out0}

Behaviour:
- All outputs registered except cmd_ready/op_ready (decoded from state).
- Reset values: state IDLE, mac_cset=0, mac_en=0, mac_a=mac_b=0, mac_cfg=0, res_valid=0, res_data=0, busy=0, beat counter=0.
- States:
  - IDLE: cmd_ready=1. On cmd_valid: latch cfg/init/len, go CONFIG.
  - CONFIG (exactly 1 cycle): mac_cset=1, mac_en=0, mac_cfg = latched value. Next state: len==0 -> CAPTURE; else STREAM.
  - STREAM: op_ready=1 while remaining>0. On accepted beat in cycle t: mac_a/mac_b=op data and mac_en=1 in cycle t+1; remaining decrements. Cycle with no accepted beat -> mac_en=0 next cycle (cluster frozen), mac_a/mac_b hold. Last beat accepted -> DRAIN.
  - DRAIN: drive MAC_LATENCY-1 cycles of mac_en=1 with mac_a=mac_b=0 after the last-beat cycle, then CAPTURE.
  - CAPTURE (1 cycle, mac_en=0): register res_data=mac_out, go RESULT.
  - RESULT: res_valid=1, res_data stable until res_ready; then -> IDLE, res_valid=0 the next cycle.
- Timing:
  - Last beat applied in cycle k: mac_out sampled in cycle k+MAC_LATENCY; res_valid rises in cycle k+MAC_LATENCY+1.
  - len=0: cset in cycle c, mac_out (= init values) sampled in cycle c+1, res_valid in c+2.
- mac_cfg held constant from CONFIG until the next command's CONFIG; never changes mid-job.
- Zero drain beats are harmless: capture timing excludes them in non-accumulate mode, and they add 0 in accumulate mode.
- No new command accepted until the current result handshakes; there is no pipelining across jobs.
- op beats offered outside STREAM, or after the count is exhausted, are not accepted (op_ready=0).
- Result width: res_data is the raw cluster value; wrap/sign-extension semantics are the cluster's. Lanes are packed per mode: dual pairs {1,0},{3,2}; quad all four.
- Reset mid-job (any state): abort with no result; next cycle mac_cset=0, mac_en=0, IDLE. The cluster's own reset is separate and not driven here.
- Zero-width stalls (op_valid low, res_ready low) are unbounded; no timeouts.

Test Plan:
- SINGLE unsigned accumulate (cfg=4'b0100), init all 0, len=3, beats A=B={4{8'd2}} -> res_data lanes each 12; res_valid exactly 2 cycles after last mac_en beat.
- SINGLE signed non-accumulate (cfg=4'b1000), len=2, beat1 A0=-3,B0=5; beat2 A0=-4,B0=-4 -> out0=16 (last product only); drain zeros do not corrupt.
- QUAD unsigned accumulate (cfg=4'b0110), init0=100 others 0, len=1, {A}=32'd65536, {B}=32'd3 -> 128-bit result = 196708 across lanes.
- len=0 with init={4,3,2,1} -> res_data={4,3,2,1}; CONFIG->CAPTURE, res_valid 2 cycles after cset.
- Stalls: op_valid toggled 1/0, res_ready held low 5 cycles -> mac_en=0 exactly on bubble cycles, result identical to no-stall run, res_data stable while held.
- Reset asserted mid-STREAM after 2 of 4 beats -> next cycle IDLE, busy=0, mac_en=0, no res_valid; a new job then completes correctly.
